// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared widths, grant encoding and the writeback request word for the GPR write port.
package gpr_wb_arbiter_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int ADDR_W = $clog2(NREG);

   typedef enum logic {
      GRANT_EXU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [XLEN-1:0]   dat;
   } wb_req_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-load scoreboard: one bit per GPR (x0 constant 0) plus three busy queries.
// Latency: set/clear visible the cycle after; queries are combinational.
// Backpressure: none; busy outputs are what IDU stalls on.
module gpr_scoreboard
   import gpr_wb_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              set_vld,
   input  logic [ADDR_W-1:0] set_rd,
   input  logic              clr_vld,
   input  logic [ADDR_W-1:0] clr_rd,
   input  logic              wb_vld,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [ADDR_W-1:0] chk_rs1,
   input  logic [ADDR_W-1:0] chk_rs2,
   input  logic [ADDR_W-1:0] chk_rd,
   output logic              busy_rs1,
   output logic              busy_rs2,
   output logic              busy_rd,
   output logic [NREG-1:0]   pend
);

   logic [NREG-1:1] sb_q;
   logic [NREG-1:1] sb_nxt;

   // Clear is applied before set so a reissued load to the register being written back stays pending.
   always_comb begin
      sb_nxt = sb_q;
      for (int i = 1; i < NREG; i++) begin
         if (clr_vld && clr_rd == ADDR_W'(i)) sb_nxt[i] = 1'b0;
         if (set_vld && set_rd == ADDR_W'(i)) sb_nxt[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sb_q <= '0;
      else      sb_q <= sb_nxt;
   end

   assign pend = {sb_q, 1'b0};

   // The writeback-stage term covers an EXU result not yet in the GPR.
   assign busy_rs1 = pend[chk_rs1] | (wb_vld && wb_rd == chk_rs1 && chk_rs1 != '0);
   assign busy_rs2 = pend[chk_rs2] | (wb_vld && wb_rd == chk_rs2 && chk_rs2 != '0);
   assign busy_rd  = pend[chk_rd]  | (wb_vld && wb_rd == chk_rd  && chk_rd  != '0);

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter between EXU and LSU for the single GPR write port, one writeback register stage.
// Latency: handshake in cycle N drives RegWEn/addr_towrite/data_towrite in N+1.
// Backpressure: the stage drains every cycle; only the arbitration loser sees ready low.
module gpr_wb_arbiter
   import gpr_wb_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              exu_valid,
   output logic              exu_ready,
   input  logic [ADDR_W-1:0] exu_rd,
   input  logic [XLEN-1:0]   exu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   input  logic              sb_set,
   input  logic [ADDR_W-1:0] sb_set_rd,
   input  logic [ADDR_W-1:0] chk_rs1,
   input  logic [ADDR_W-1:0] chk_rs2,
   input  logic [ADDR_W-1:0] chk_rd,
   output logic              busy_rs1,
   output logic              busy_rs2,
   output logic              busy_rd,
   output logic              RegWEn,
   output logic [ADDR_W-1:0] addr_towrite,
   output logic [XLEN-1:0]   data_towrite
);

   grant_e          last_grant;
   logic            grant_exu;
   logic            grant_lsu;
   logic            wb_from_lsu;
   logic            sb_clr;
   wb_req_t         win;
   logic [NREG-1:0] pend;

   always_comb begin
      grant_lsu = lsu_valid & (~exu_valid | (last_grant == GRANT_EXU));
      grant_exu = exu_valid & ~grant_lsu;
      win.rd    = grant_lsu ? lsu_rd   : exu_rd;
      win.dat   = grant_lsu ? lsu_data : exu_data;
   end

   assign exu_ready = exu_valid & grant_exu;
   assign lsu_ready = lsu_valid & grant_lsu;

   // x0 requests are consumed but never reach the GPR.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWEn       <= 1'b0;
         addr_towrite <= '0;
         data_towrite <= '0;
         wb_from_lsu  <= 1'b0;
         last_grant   <= GRANT_EXU;
      end else if (exu_ready | lsu_ready) begin
         RegWEn       <= (win.rd != '0);
         addr_towrite <= win.rd;
         data_towrite <= win.dat;
         wb_from_lsu  <= lsu_ready;
         last_grant   <= lsu_ready ? GRANT_LSU : GRANT_EXU;
      end else begin
         RegWEn       <= 1'b0;
         wb_from_lsu  <= 1'b0;
      end
   end

   assign sb_clr = RegWEn & wb_from_lsu;

   gpr_scoreboard u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_vld  (sb_set),
      .set_rd   (sb_set_rd),
      .clr_vld  (sb_clr),
      .clr_rd   (addr_towrite),
      .wb_vld   (RegWEn),
      .wb_rd    (addr_towrite),
      .chk_rs1  (chk_rs1),
      .chk_rs2  (chk_rs2),
      .chk_rd   (chk_rd),
      .busy_rs1 (busy_rs1),
      .busy_rs2 (busy_rs2),
      .busy_rd  (busy_rd),
      .pend     (pend)
   );

   // A register whose load is writing back this cycle may be reissued.
   a_set_busy : assert property (@(posedge clk) disable iff (!rst)
      (sb_set && sb_set_rd != '0) |-> (!pend[sb_set_rd] || (sb_clr && addr_towrite == sb_set_rd)));
   a_exu_busy : assert property (@(posedge clk) disable iff (!rst)
      (exu_ready && exu_rd != '0) |-> (!pend[exu_rd] || (sb_clr && addr_towrite == exu_rd)));
   a_lsu_idle : assert property (@(posedge clk) disable iff (!rst)
      (lsu_ready && lsu_rd != '0) |-> pend[lsu_rd]);

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed literal checks plus randomized legal traffic against a rule-level model of the writeback port.
module tb_gpr_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_valid, exu_ready;
   logic [4:0]  exu_rd;
   logic [31:0] exu_data;
   logic        lsu_valid, lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        sb_set;
   logic [4:0]  sb_set_rd;
   logic [4:0]  chk_rs1, chk_rs2, chk_rd;
   logic        busy_rs1, busy_rs2, busy_rd;
   logic        RegWEn;
   logic [4:0]  addr_towrite;
   logic [31:0] data_towrite;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // Model state: pending loads, the write the GPR sees this cycle, who won last.
   bit [31:0] m_pend;
   bit        m_we;
   bit [4:0]  m_addr;
   bit [31:0] m_data;
   bit        m_from_lsu;
   bit        m_last_lsu;
   bit        m_acc_exu, m_acc_lsu;
   bit        g_exu, g_lsu;
   bit [31:0] ld_out;

   always #5 clk = ~clk;

   gpr_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .sb_set(sb_set), .sb_set_rd(sb_set_rd),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
      .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_rd(busy_rd),
      .RegWEn(RegWEn), .addr_towrite(addr_towrite), .data_towrite(data_towrite)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_busy(input logic [4:0] q);
      return (q != 0) && (m_pend[q] || (m_we && m_addr == q));
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         m_pend = '0; m_we = 0; m_addr = 0; m_data = 0;
         m_from_lsu = 0; m_last_lsu = 0; m_acc_exu = 0; m_acc_lsu = 0;
      end else if (chk_en) begin
         g_lsu = lsu_valid && (!exu_valid || !m_last_lsu);
         g_exu = exu_valid && !g_lsu;
         chk("exu_ready", 32'(exu_ready), 32'(g_exu));
         chk("lsu_ready", 32'(lsu_ready), 32'(g_lsu));
         chk("busy_rs1", 32'(busy_rs1), 32'(m_busy(chk_rs1)));
         chk("busy_rs2", 32'(busy_rs2), 32'(m_busy(chk_rs2)));
         chk("busy_rd", 32'(busy_rd), 32'(m_busy(chk_rd)));
         chk("RegWEn", 32'(RegWEn), 32'(m_we));
         chk("addr_towrite", 32'(addr_towrite), 32'(m_addr));
         chk("data_towrite", data_towrite, m_data);
         if (m_we && m_from_lsu) m_pend[m_addr] = 1'b0;
         if (sb_set && sb_set_rd != 0) m_pend[sb_set_rd] = 1'b1;
         m_acc_exu = g_exu;
         m_acc_lsu = g_lsu;
         if (g_exu || g_lsu) begin
            m_addr     = g_lsu ? lsu_rd : exu_rd;
            m_data     = g_lsu ? lsu_data : exu_data;
            m_we       = (m_addr != 0);
            m_from_lsu = g_lsu;
            m_last_lsu = g_lsu;
         end else begin
            m_we       = 1'b0;
            m_from_lsu = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exu_valid = 0; lsu_valid = 0; sb_set = 0;
   endtask

   initial begin
      int r;
      int rr;
      rst = 0;
      idle();
      exu_rd = 0; exu_data = 0; lsu_rd = 0; lsu_data = 0; sb_set_rd = 0;
      chk_rs1 = 5; chk_rs2 = 7; chk_rd = 9;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_RegWEn", 32'(RegWEn), 32'd0);
      chk("rst_addr", 32'(addr_towrite), 32'd0);
      chk("rst_data", data_towrite, 32'd0);
      rst = 1; chk_en = 1;
      #1;
      chk("idle_busy", 32'({busy_rs1, busy_rs2, busy_rd}), 32'd0);

      // EXU alone, rd=5
      step(); exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF; #1;
      chk("t2_ready", 32'(exu_ready), 32'd1);
      chk("t2_busy_n", 32'(busy_rs1), 32'd0);
      step(); idle(); #1;
      chk("t2_we", 32'(RegWEn), 32'd1);
      chk("t2_addr", 32'(addr_towrite), 32'd5);
      chk("t2_data", data_towrite, 32'hDEADBEEF);
      chk("t2_busy_n1", 32'(busy_rs1), 32'd1);
      step(); #1;
      chk("t2_busy_n2", 32'(busy_rs1), 32'd0);

      // Round robin with both requesters valid for three cycles
      step(); sb_set = 1; sb_set_rd = 4;
      step(); sb_set_rd = 6;
      step(); sb_set = 0;
      exu_valid = 1; exu_rd = 3; exu_data = 32'h33;
      lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44; #1;
      chk("t3_a_lsu", 32'(lsu_ready), 32'd1);
      chk("t3_a_exu", 32'(exu_ready), 32'd0);
      step(); lsu_rd = 6; lsu_data = 32'h66; #1;
      chk("t3_b_exu", 32'(exu_ready), 32'd1);
      chk("t3_b_lsu", 32'(lsu_ready), 32'd0);
      chk("t3_b_addr", 32'(addr_towrite), 32'd4);
      chk("t3_b_data", data_towrite, 32'h44);
      step(); exu_rd = 8; exu_data = 32'h88; #1;
      chk("t3_c_lsu", 32'(lsu_ready), 32'd1);
      chk("t3_c_exu", 32'(exu_ready), 32'd0);
      chk("t3_c_addr", 32'(addr_towrite), 32'd3);
      step(); lsu_valid = 0; #1;
      chk("t3_d_exu", 32'(exu_ready), 32'd1);
      chk("t3_d_addr", 32'(addr_towrite), 32'd6);
      chk("t3_d_data", data_towrite, 32'h66);
      step(); idle(); #1;
      chk("t3_e_addr", 32'(addr_towrite), 32'd8);
      chk("t3_e_we", 32'(RegWEn), 32'd1);

      // Load to rd=7 stays busy through its writeback cycle
      step(); sb_set = 1; sb_set_rd = 7;
      step(); sb_set = 0; chk_rs2 = 7;
      for (int i = 0; i < 5; i++) begin
         #1; chk("t4_busy_wait", 32'(busy_rs2), 32'd1);
         step();
      end
      lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234; #1;
      chk("t4_lsu_ready", 32'(lsu_ready), 32'd1);
      step(); lsu_valid = 0; #1;
      chk("t4_we", 32'(RegWEn), 32'd1);
      chk("t4_data", data_towrite, 32'h1234);
      chk("t4_busy_wb", 32'(busy_rs2), 32'd1);
      step(); #1;
      chk("t4_busy_after", 32'(busy_rs2), 32'd0);

      // x0 writes and x0 scoreboard sets are no-ops
      step(); exu_valid = 1; exu_rd = 0; exu_data = 32'hFFFF_FFFF; #1;
      chk("t5_ready", 32'(exu_ready), 32'd1);
      step(); idle(); sb_set = 1; sb_set_rd = 0; chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0; #1;
      chk("t5_we", 32'(RegWEn), 32'd0);
      step(); sb_set = 0; #1;
      chk("t5_busy", 32'({busy_rs1, busy_rs2, busy_rd}), 32'd0);

      // Reissue of rd=9 during its own LSU writeback: set wins
      step(); sb_set = 1; sb_set_rd = 9;
      step(); sb_set = 0; lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99; #1;
      chk("t6_lsu_ready", 32'(lsu_ready), 32'd1);
      step(); lsu_valid = 0; sb_set = 1; sb_set_rd = 9; chk_rd = 9; #1;
      chk("t6_we", 32'(RegWEn), 32'd1);
      chk("t6_busy_wb", 32'(busy_rd), 32'd1);
      step(); sb_set = 0; #1;
      chk("t6_busy_after", 32'(busy_rd), 32'd1);
      chk("t6_we_after", 32'(RegWEn), 32'd0);

      // Random legal traffic
      step(); idle();
      ld_out = m_pend;
      for (int c = 0; c < 3000; c++) begin
         step();
         if (!exu_valid || m_acc_exu) begin
            r = int'($urandom_range(0, 31));
            exu_valid = 0;
            if ($urandom_range(0, 1) == 1 && !m_pend[r]) begin
               exu_valid = 1; exu_rd = 5'(r); exu_data = $urandom;
            end
         end
         if (!lsu_valid || m_acc_lsu) begin
            r = int'($urandom_range(0, 31));
            lsu_valid = 0;
            if ($urandom_range(0, 1) == 1 && ld_out[r]) begin
               lsu_valid = 1; lsu_rd = 5'(r); lsu_data = $urandom; ld_out[r] = 1'b0;
            end
         end
         r = int'($urandom_range(0, 31));
         sb_set = 0;
         sb_set_rd = 5'(r);
         if ($urandom_range(0, 2) == 0 && !m_pend[r] && !ld_out[r]
             && !(exu_valid && exu_rd == 5'(r)) && !(lsu_valid && lsu_rd == 5'(r))
             && !(m_we && m_addr == 5'(r))) begin
            sb_set = 1;
            if (r != 0) ld_out[r] = 1'b1;
         end
         chk_rs1 = 5'($urandom_range(0, 31));
         chk_rs2 = 5'($urandom_range(0, 31));
         chk_rd  = 5'($urandom_range(0, 31));
      end

      // Reset while a write is in the writeback stage
      step(); idle();
      step(); step();
      rr = 1;
      for (int i = 31; i >= 1; i--) if (!m_pend[i]) rr = i;
      exu_valid = 1; exu_rd = 5'(rr); exu_data = 32'hA5A5_A5A5;
      step(); exu_valid = 0; chk_rs1 = 5'(rr); #1;
      chk("rmid_we_before", 32'(RegWEn), 32'd1);
      rst = 0; #1;
      chk("rmid_we", 32'(RegWEn), 32'd0);
      chk("rmid_addr", 32'(addr_towrite), 32'd0);
      chk("rmid_data", data_towrite, 32'd0);
      chk("rmid_busy", 32'(busy_rs1), 32'd0);
      step(); step();
      rst = 1;
      step(); #1;
      chk("rmid_we_after", 32'(RegWEn), 32'd0);
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
